circle_draw_unit: RTL and testbench

- Parametrised next-generation circle drawing unit for the framestore drawing engine.
- Accepts a command through the req/ack register interface and runs Bresenham's midpoint circle algorithm.
- Emits one pixel write per de_req/de_ack transaction.
- Adds over the previous generation:
  - configurable framestore geometry;
  - per-pixel clipping to the framestore bounds;
  - a filled-disc mode that draws horizontal spans;
  - synchronous reset.

---
 rtl/circle_draw_unit.sv | 171 +++++++++++++++++
 tb/tb_circle_draw_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/circle_draw_unit.sv
// rtl/circle_draw_unit.sv - midpoint circle / filled disc rasteriser with clipping
// Emits one framestore pixel write per de_req/de_ack handshake.
module circle_draw_unit #(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int DE_ADDR_W = 18,
  parameter int E_W       = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  output logic                 ack,
  output logic                 busy,
  input  logic [15:0]          r0,
  input  logic [15:0]          r1,
  input  logic [15:0]          r2,
  input  logic [15:0]          r3,
  input  logic [15:0]          r4,
  input  logic [15:0]          r5,
  input  logic [15:0]          r6,
  input  logic [15:0]          r7,
  output logic                 de_req,
  input  logic                 de_ack,
  output logic [DE_ADDR_W-1:0] de_addr,
  output logic [3:0]           de_nbyte,
  output logic                 de_rnw,
  output logic [31:0]          de_w_data,
  input  logic [31:0]          de_r_data
);
  localparam int AW = DE_ADDR_W + 2;
  localparam logic [2:0] IDLE = 3'd0, SETUP = 3'd1, PLOT = 3'd2, NEXT = 3'd3, STEP = 3'd4;
  localparam logic signed [E_W-1:0] ZERO = '0;
  localparam logic signed [E_W-1:0] ONE  = E_W'(1);
  localparam logic signed [E_W-1:0] C3   = E_W'(3);
  localparam logic signed [E_W-1:0] C6   = E_W'(6);
  localparam logic signed [E_W-1:0] C10  = E_W'(10);
  localparam logic signed [E_W-1:0] W_S  = E_W'(WIDTH);
  localparam logic signed [E_W-1:0] H_S  = E_W'(HEIGHT);

  logic [2:0] state;
  logic signed [E_W-1:0] xc, yc, x, y, e, sx;
  logic [7:0] colour;
  logic fill;
  logic [2:0] idx;

  logic signed [E_W-1:0] dx, dy, px, py, half, x_n, y_n, e_n;
  logic vis;
  logic [AW-1:0] a;
  logic unused;

  assign de_rnw = 1'b0;
  assign unused = ^{r2[15:12], r3[15:8], r4[15:1], r5, r6, r7, de_r_data};

  // Offset of the current point from the centre; in filled mode sx walks the span.
  always_comb begin
    dx   = ZERO;
    dy   = ZERO;
    half = idx[1] ? y : x;
    if (fill) begin
      dx = sx;
      case (idx[1:0])
        2'd0:    dy = y;
        2'd1:    dy = -y;
        2'd2:    dy = x;
        default: dy = -x;
      endcase
    end else begin
      case (idx)
        3'd0:    begin dx = x;  dy = y;  end
        3'd1:    begin dx = y;  dy = x;  end
        3'd2:    begin dx = y;  dy = -x; end
        3'd3:    begin dx = x;  dy = -y; end
        3'd4:    begin dx = -x; dy = -y; end
        3'd5:    begin dx = -y; dy = -x; end
        3'd6:    begin dx = -y; dy = x;  end
        default: begin dx = -x; dy = y;  end
      endcase
    end
    px  = xc + dx;
    py  = yc + dy;
    vis = !(px < ZERO || px >= W_S || py < ZERO || py >= H_S);
    a   = AW'(px) + AW'(WIDTH) * AW'(py);
    if (e > ZERO) begin
      e_n = e + ((x - y) <<< 2) + C10;
      y_n = y - ONE;
    end else begin
      e_n = e + (x <<< 2) + C6;
      y_n = y;
    end
    x_n = x + ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ack       <= 1'b0;
      busy      <= 1'b0;
      de_req    <= 1'b0;
      de_addr   <= '0;
      de_nbyte  <= 4'b1111;
      de_w_data <= '0;
      xc <= ZERO; yc <= ZERO; x <= ZERO; y <= ZERO; e <= ZERO; sx <= ZERO;
      colour <= '0;
      fill   <= 1'b0;
      idx    <= '0;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: if (req && !ack) begin
          ack    <= 1'b1;
          busy   <= 1'b1;
          xc     <= E_W'(r0);
          yc     <= E_W'(r1);
          x      <= ZERO;
          y      <= E_W'(r2[11:0]);
          e      <= C3 - (E_W'(r2[11:0]) <<< 2);
          colour <= r3[7:0];
          fill   <= r4[0];
          idx    <= '0;
          sx     <= ZERO;
          state  <= SETUP;
        end
        SETUP: if (vis) begin
          de_req    <= 1'b1;
          de_addr   <= a[AW-1:2];
          de_nbyte  <= ~(4'b0001 << a[1:0]);
          de_w_data <= {4{colour}};
          state     <= PLOT;
        end else begin
          state <= NEXT;
        end
        PLOT: if (de_ack) begin
          de_req <= 1'b0;
          state  <= NEXT;
        end
        NEXT: if (fill) begin
          if (sx < half) begin
            sx    <= sx + ONE;
            state <= SETUP;
          end else if (idx == 3'd3) begin
            state <= STEP;
          end else begin
            // Spans 0,1 are half-width x; spans 2,3 are half-width y.
            idx   <= idx + 3'd1;
            sx    <= (idx == 3'd0) ? -x : -y;
            state <= SETUP;
          end
        end else if (idx == 3'd7) begin
          state <= STEP;
        end else begin
          idx   <= idx + 3'd1;
          state <= SETUP;
        end
        STEP: begin
          e   <= e_n;
          y   <= y_n;
          x   <= x_n;
          idx <= '0;
          sx  <= -x_n;
          if (x_n > y_n) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= SETUP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_circle_draw_unit.sv
// tb/tb_circle_draw_unit.sv - scoreboard bench for circle_draw_unit
// Directed commands push expected writes; a negedge monitor pops and compares.
module tb_circle_draw_unit;
  logic clk = 1'b0;
  logic rst, req, ack, busy;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic de_req, de_ack, de_rnw;
  logic [17:0] de_addr;
  logic [3:0] de_nbyte;
  logic [31:0] de_w_data, de_r_data;

  circle_draw_unit dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .busy(busy),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
    .de_req(de_req), .de_ack(de_ack), .de_addr(de_addr), .de_nbyte(de_nbyte),
    .de_rnw(de_rnw), .de_w_data(de_w_data), .de_r_data(de_r_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int writes = 0;
  int acks = 0;
  int hold_at = -1;
  int hold_len = 0;
  int wait_cnt = 0;
  logic [53:0] exp_q[$];
  logic prev_req = 1'b0;
  logic [53:0] held = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  function automatic logic [53:0] pix(input int px, input int py, input logic [7:0] col);
    logic [19:0] av;
    av = 20'(px + 640 * py);
    return {av[19:2], ~(4'b0001 << av[1:0]), {4{col}}};
  endfunction

  task automatic push(input int px, input int py, input logic [7:0] col);
    exp_q.push_back(pix(px, py, col));
  endtask

  // Write acceptor: acks one cycle after de_req, optionally stalling one chosen write.
  initial begin
    de_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (de_ack) begin
        de_ack = 1'b0;
        acks++;
      end else if (de_req) begin
        if (acks == hold_at && wait_cnt < hold_len) wait_cnt++;
        else begin
          de_ack = 1'b1;
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: output stability while requesting, and scoreboard compare per accepted write.
  always @(negedge clk) begin
    if (de_req && prev_req) check("hold", {de_addr, de_nbyte, de_w_data}, held);
    held = {de_addr, de_nbyte, de_w_data};
    prev_req = de_req;
    if (de_req && de_ack) begin
      writes++;
      check("rnw", de_rnw, 0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_write: got %h want none", {de_addr, de_nbyte, de_w_data});
      end else begin
        check("write", {de_addr, de_nbyte, de_w_data}, exp_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [15:0] x0, input logic [15:0] y0, input logic [15:0] rad,
                       input logic [15:0] col, input logic [15:0] md);
    int n;
    @(negedge clk);
    r0 = x0; r1 = y0; r2 = rad; r3 = col; r4 = md;
    req = 1'b1;
    n = 0;
    while (!ack && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("ack_seen", ack, 1);
    check("busy_on", busy, 1);
    repeat (3) begin
      @(negedge clk);
      check("ack_once", ack, 0);
    end
    req = 1'b0;
  endtask

  task automatic finish_cmd(input int base, input int nexp);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("busy_off", busy, 0);
    check("write_count", writes - base, nexp);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic outline_r1_expect();
    push(100, 101, 8'h5A); push(101, 100, 8'h5A); push(101, 100, 8'h5A); push(100, 99, 8'h5A);
    push(100, 99, 8'h5A);  push(99, 100, 8'h5A);  push(99, 100, 8'h5A);  push(100, 101, 8'h5A);
    push(101, 101, 8'h5A); push(101, 101, 8'h5A); push(101, 99, 8'h5A);  push(101, 99, 8'h5A);
    push(99, 99, 8'h5A);   push(99, 99, 8'h5A);   push(99, 101, 8'h5A);  push(99, 101, 8'h5A);
  endtask

  initial begin
    int base, n;
    rst = 1'b1; req = 1'b0;
    r0 = '0; r1 = '0; r2 = '0; r3 = '0; r4 = '0; r5 = '0; r6 = '0; r7 = '0;
    de_r_data = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_de_req", de_req, 0);
    check("rst_addr", de_addr, 0);
    check("rst_nbyte", de_nbyte, 4'b1111);
    check("rst_wdata", de_w_data, 0);
    rst = 1'b0;

    // r=0 outline: eight writes of the centre pixel
    base = writes;
    for (int i = 0; i < 8; i++) exp_q.push_back({18'd802, 4'b1011, 32'h3C3C3C3C});
    issue(16'd10, 16'd5, 16'd0, 16'h003C, 16'd0);
    finish_cmd(base, 8);

    // r=1 outline around (100,100)
    base = writes;
    outline_r1_expect();
    issue(16'd100, 16'd100, 16'd1, 16'h005A, 16'd0);
    finish_cmd(base, 16);
    check("final_e", dut.e, 20'd15);

    // clipped outline at the origin
    base = writes;
    push(0, 1, 8'hC3); push(1, 0, 8'hC3); push(1, 0, 8'hC3);
    push(0, 1, 8'hC3); push(1, 1, 8'hC3); push(1, 1, 8'hC3);
    issue(16'd0, 16'd0, 16'd1, 16'hFFC3, 16'd0);
    finish_cmd(base, 6);

    // filled r=1 disc, third write stalled for 5 cycles
    base = writes;
    hold_at = acks + 2;
    hold_len = 5;
    push(100, 101, 8'h81); push(100, 99, 8'h81);
    for (int k = 0; k < 2; k++) for (int c = 99; c <= 101; c++) push(c, 100, 8'h81);
    for (int k = 0; k < 2; k++) begin
      for (int c = 99; c <= 101; c++) push(c, 101, 8'h81);
      for (int c = 99; c <= 101; c++) push(c, 99, 8'h81);
    end
    issue(16'd100, 16'd100, 16'd1, 16'h0081, 16'hFFFF);
    finish_cmd(base, 20);
    hold_at = -1;

    // reset during the 4th write of the r=1 outline
    base = writes;
    hold_at = acks + 3;
    hold_len = 1000;
    push(100, 101, 8'h5A); push(101, 100, 8'h5A); push(101, 100, 8'h5A);
    issue(16'd100, 16'd100, 16'd1, 16'h005A, 16'd0);
    n = 0;
    while (!(writes - base == 3 && de_req) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_req", de_req, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_de_req", de_req, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_state", dut.state, 0);
    check("mid_rst_writes", writes - base, 3);
    check("mid_rst_queue", exp_q.size(), 0);
    rst = 1'b0;
    hold_at = -1;

    base = writes;
    outline_r1_expect();
    issue(16'd100, 16'd100, 16'd1, 16'h005A, 16'd0);
    finish_cmd(base, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
